// File: rtl/simplediv_pkg.sv
// Shared definitions for the iterative restoring divider.
package simplediv_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FIXUP = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // STEPS must divide XLEN evenly into a whole number of clock cycles.
  function automatic bit steps_legal(input int unsigned s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 8) || (s == 16) || (s == 32);
  endfunction

endpackage

// File: rtl/simplediv_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module simplediv_step
  import simplediv_pkg::*;
(
  input  logic [XLEN:0]   r,
  input  logic            a_msb,
  input  logic [XLEN-1:0] d,
  output logic [XLEN:0]   r_next,
  output logic            qbit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // 33-bit compare so a divisor with bit 31 set is handled correctly.
  always_comb begin
    shifted = {r[XLEN-1:0], a_msb};
    diff    = shifted - {1'b0, d};
    qbit    = (shifted >= {1'b0, d});
    r_next  = qbit ? diff : shifted;
  end

endmodule

// File: rtl/simplediv.sv
// Multi-cycle 32-bit divider for DIV/DIVU/REM/REMU with start/busy/done
// handshake. rd = {remainder, quotient}; STEPS quotient bits per clock.
module simplediv
  import simplediv_pkg::*;
#(
  parameter int unsigned STEPS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [63:0] rd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CYCLES = XLEN / STEPS;
  localparam logic [5:0]  LAST   = 6'(CYCLES - 1);

  if (!steps_legal(STEPS)) begin : g_bad_steps
    $error("simplediv: STEPS must be one of 1, 2, 4, 8, 16, 32");
  end

  state_t          state;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] d_q;
  logic [XLEN:0]   r_q;
  logic [5:0]      cnt_q;
  logic            q_sign;
  logic            r_sign;
  logic            div_zero;

  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  logic [XLEN:0]   r_ch [STEPS+1];
  logic [XLEN-1:0] a_ch [STEPS+1];

  assign r_ch[0] = r_q;
  assign a_ch[0] = a_q;

  // Chain of STEPS iterations; quotient bits shift into the low end of a.
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic qb;
    simplediv_step u_step (
      .r      (r_ch[i]),
      .a_msb  (a_ch[i][XLEN-1]),
      .d      (d_q),
      .r_next (r_ch[i+1]),
      .qbit   (qb)
    );
    assign a_ch[i+1] = {a_ch[i][XLEN-2:0], qb};
  end

  // Operand magnitudes; 0x80000000 negates to itself, read as unsigned 2^31.
  always_comb begin
    mag1 = (sign && rs1[XLEN-1]) ? -rs1 : rs1;
    mag2 = (sign && rs2[XLEN-1]) ? -rs2 : rs2;
  end

  // Sign correction; a zero divisor keeps the all-ones quotient unnegated.
  always_comb begin
    quo = (q_sign && !div_zero) ? -a_q : a_q;
    rem = r_sign ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
  end

  // Sequencer: start restarts from any state; rd is only written in FIXUP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      div_zero <= 1'b0;
      rd       <= '0;
    end else if (start) begin
      state    <= ST_RUN;
      a_q      <= mag1;
      d_q      <= mag2;
      r_q      <= '0;
      cnt_q    <= '0;
      q_sign   <= (rs1[XLEN-1] ^ rs2[XLEN-1]) & sign;
      r_sign   <= rs1[XLEN-1] & sign;
      div_zero <= (rs2 == '0);
    end else begin
      case (state)
        ST_RUN: begin
          r_q   <= r_ch[STEPS];
          a_q   <= a_ch[STEPS];
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          rd    <= {rem, quo};
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_FIXUP);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_simplediv.sv
// Self-checking bench for simplediv: directed vectors, restart/reset
// sequences and a randomized sweep over STEPS = 4, 1 and 32.
module tb_simplediv;

  logic        clock;
  logic        reset;
  logic        sign;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        start_v [3];
  logic [63:0] rd_v    [3];
  logic        busy_v  [3];
  logic        done_v  [3];

  int n_tests;
  int n_fail;

  int lat_v [3];

  simplediv #(.STEPS(4)) dut4 (
    .clock(clock), .reset(reset), .start(start_v[0]), .sign(sign),
    .rs1(rs1), .rs2(rs2), .rd(rd_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  simplediv #(.STEPS(1)) dut1 (
    .clock(clock), .reset(reset), .start(start_v[1]), .sign(sign),
    .rs1(rs1), .rs2(rs2), .rd(rd_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  simplediv #(.STEPS(32)) dut32 (
    .clock(clock), .reset(reset), .start(start_v[2]), .sign(sign),
    .rs1(rs1), .rs2(rs2), .rd(rd_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [8];

  // Behavioural reference using plain language division semantics.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Launch one operation on instance idx and check latency, handshake and rd.
  // Operand inputs are scrambled while the divider runs.
  task automatic do_op(input int idx, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input string nm);
    int first;
    int bad;
    logic [63:0] got;
    int lat;
    lat   = lat_v[idx];
    first = 0;
    bad   = 0;
    got   = '0;
    @(negedge clock);
    sign = s; rs1 = a; rs2 = b; start_v[idx] = 1'b1;
    @(negedge clock);
    start_v[idx] = 1'b0;
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      if (cyc > 1) @(negedge clock);
      rs1  = $urandom;
      rs2  = $urandom;
      sign = 1'($urandom_range(0, 1));
      if (done_v[idx] && first == 0) begin
        first = cyc;
        got   = rd_v[idx];
      end
      if (cyc <= lat && busy_v[idx] !== (cyc < lat)) bad++;
      if (cyc != lat && done_v[idx] !== 1'b0) bad++;
      if (busy_v[idx] && done_v[idx]) bad++;
    end
    chk({nm, " latency"}, 64'(first), 64'(lat));
    chk({nm, " handshake errors"}, 64'(bad), 64'd0);
    chk({nm, " rd"}, got, exp);
    chk({nm, " rd held"}, rd_v[idx], exp);
  endtask

  initial begin
    int pulses;
    int pulse_cyc;
    logic [63:0] rd_at;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;

    n_tests = 0;
    n_fail  = 0;
    lat_v   = '{10, 34, 3};

    tbl[0] = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD}};
    tbl[3] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          {32'hFFFF_FFF9,  32'hFFFF_FFFF}};
    tbl[4] = '{1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFF_FFFF}};
    tbl[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  {32'h7FFF_FFFF,  32'd1}};
    tbl[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}};

    reset = 1'b1;
    sign  = 1'b0;
    rs1   = '0;
    rs2   = '0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset rd[%0d]", i), rd_v[i], 64'd0);
      chk($sformatf("reset busy/done[%0d]", i), {62'd0, busy_v[i], done_v[i]}, 64'd0);
    end
    reset = 1'b0;

    // Directed vectors on the STEPS=4 instance.
    for (int i = 0; i < 8; i++)
      do_op(0, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    // Restart while busy: only the second operation produces a done pulse.
    @(negedge clock);
    sign = 1'b0; rs1 = 32'd1000; rs2 = 32'd3; start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clock);
    rs1 = 32'd81; rs2 = 32'd9; start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    pulses    = 0;
    pulse_cyc = 0;
    rd_at     = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clock);
      if (done_v[0]) begin
        pulses++;
        pulse_cyc = cyc;
        rd_at     = rd_v[0];
      end
    end
    chk("restart done pulses", 64'(pulses), 64'd1);
    chk("restart latency", 64'(pulse_cyc), 64'd10);
    chk("restart rd", rd_at, {32'd0, 32'd9});

    // Asynchronous reset between edges mid-operation.
    @(negedge clock);
    sign = 1'b0; rs1 = 32'd1000; rs2 = 32'd3; start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy/done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
    chk("async reset rd", rd_v[0], 64'd0);
    @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clock);
      if (done_v[0] || busy_v[0]) pulses++;
    end
    chk("post-reset activity", 64'(pulses), 64'd0);
    do_op(0, 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, "post-reset op");

    // Randomized sweep on all three STEPS variants.
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 25; n++) begin
        s = 1'($urandom_range(0, 1));
        a = $urandom;
        case ($urandom_range(0, 9))
          0: b = 32'd0;
          1: begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2, 3: b = 32'($urandom_range(1, 15));
          4: b = -32'($urandom_range(1, 15));
          default: b = $urandom;
        endcase
        do_op(idx, s, a, b, ref_div(s, a, b),
              $sformatf("rand s%0d #%0d %h/%h sign%0d", idx, n, a, b, s));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
